// File: rtl/shift_iter_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package shift_iter_pkg;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/dff.sv
// Standard D flip-flop cell with synchronous active-high reset to zero.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/shift_iter_step.sv
// One 1-bit step of rotate/shift in either direction, purely combinational.
module shift_step
  import shift_iter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] In,
  input  op_t              Op,
  output logic [WIDTH-1:0] Out
);

  always_comb begin
    Out = In;
    case (Op)
      OP_ROL:  Out = {In[WIDTH-2:0], In[WIDTH-1]};
      OP_SLL:  Out = {In[WIDTH-2:0], 1'b0};
      OP_ROR:  Out = {In[0], In[WIDTH-1:1]};
      OP_SRL:  Out = {1'b0, In[WIDTH-1:1]};
      default: Out = In;
    endcase
  end

endmodule

// File: rtl/shift_iter.sv
// Iterative shifter: applies Cnt single-bit steps of the latched Op to Out, one per clock.
module shift_iter
  import shift_iter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] Out,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_raw, state_nxt_raw, op_raw, op_nxt_raw;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] out_d, step_out;
  state_t           state_q, state_d;
  op_t              op_q, op_d;

  // All state lives in dff cells; the FSM is the next-state logic below.
  dff #(.W(2))     u_state (.clk(clk), .rst(rst), .d(state_nxt_raw), .q(state_raw));
  dff #(.W(2))     u_op    (.clk(clk), .rst(rst), .d(op_nxt_raw),    .q(op_raw));
  dff #(.W(CNT_W)) u_rem   (.clk(clk), .rst(rst), .d(rem_d),         .q(rem_q));
  dff #(.W(WIDTH)) u_out   (.clk(clk), .rst(rst), .d(out_d),         .q(Out));

  assign state_q       = state_t'(state_raw);
  assign op_q          = op_t'(op_raw);
  assign state_nxt_raw = state_d;
  assign op_nxt_raw    = op_d;

  shift_step #(.WIDTH(WIDTH)) u_step (.In(Out), .Op(op_q), .Out(step_out));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    out_d   = Out;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          out_d   = In;
          op_d    = op_t'(Op);
          rem_d   = Cnt;
          state_d = (Cnt == '0) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        out_d = step_out;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_iter.sv
// Self-checking bench for shift_iter against an arithmetic shift/rotate reference model.
module tb_shift_iter;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] In, Out;
  logic [3:0]  Cnt;
  logic [1:0]  Op;
  logic        busy, done;

  int checks = 0;
  int fails  = 0;

  shift_iter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .In(In), .Cnt(Cnt), .Op(Op),
    .Out(Out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] x, input int n);
    int unsigned v;
    int unsigned r;
    v = 32'(x);
    case (op)
      2'b00: r = (v << n) | (v >> (16 - n));
      2'b01: r = v << n;
      2'b10: r = (v >> n) | (v << (16 - n));
      default: r = v >> n;
    endcase
    return r[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] x, input logic [3:0] n,
                        input bit scramble, output logic [15:0] res, output int lat,
                        output int bcnt, output bit seen);
    In = x; Cnt = n; Op = op; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      if (scramble) begin
        In = 16'($urandom); Cnt = 4'($urandom); Op = 2'($urandom); start = 1'($urandom);
      end
      tick();
      lat++;
    end
    start = 1'b0;
    res = Out;
    seen = (done === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; In = '0; Cnt = '0; Op = '0;
    tick(); tick();
    checks++;
    if (Out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset: Out=%h busy=%b done=%b, required 0000/0/0", Out, busy, done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [1:0]  ops [5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    logic [15:0] ins [5] = '{16'h0001, 16'h8001, 16'h0001, 16'h8000, 16'hA5A5};
    logic [3:0]  cnts[5] = '{4'd15, 4'd1, 4'd4, 4'd15, 4'd0};
    logic [15:0] exps[5] = '{16'h8000, 16'h0003, 16'h1000, 16'h0001, 16'hA5A5};
    logic [15:0] res;
    int lat, bcnt;
    bit seen;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], ins[i], cnts[i], 1'b0, res, lat, bcnt, seen);
      checks++;
      if (!seen || res !== exps[i]) begin
        fails++;
        $display("FAIL directed[%0d] result: Out=%h done=%b, required %h done=1", i, res, seen, exps[i]);
      end
      checks++;
      if (lat != int'(cnts[i]) || bcnt != int'(cnts[i])) begin
        fails++;
        $display("FAIL directed[%0d] timing: latency=%0d busy_cycles=%0d, required %0d/%0d",
                 i, lat, bcnt, cnts[i], cnts[i]);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || Out !== exps[i]) begin
        fails++;
        $display("FAIL directed[%0d] idle hold: Out=%h done=%b busy=%b, required %h/0/0",
                 i, Out, done, busy, exps[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] res;
    int lat;
    In = 16'h0001; Cnt = 4'd6; Op = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    In = 16'hFFFF; Cnt = 4'd3; Op = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
    res = Out;
    checks++;
    if (res !== 16'h0040 || lat != 6) begin
      fails++;
      $display("FAIL start_ignored: Out=%h latency=%0d, required 0040 latency=6", res, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] res;
    int lat, bcnt;
    bit seen;
    run_op(2'b00, 16'h4001, 4'd2, 1'b0, res, lat, bcnt, seen);
    checks++;
    if (!seen || res !== 16'h0005) begin
      fails++;
      $display("FAIL b2b first: Out=%h done=%b, required 0005 done=1", res, seen);
    end
    run_op(2'b01, 16'h0003, 4'd2, 1'b0, res, lat, bcnt, seen);
    checks++;
    if (!seen || res !== 16'h000C || lat != 2) begin
      fails++;
      $display("FAIL b2b second: Out=%h latency=%0d, required 000C latency=2", res, lat);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [15:0] res;
    int lat, bcnt;
    bit seen;
    bit saw_done;
    In = 16'h1234; Cnt = 4'd10; Op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (Out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort: Out=%h busy=%b done=%b, required 0000/0/0", Out, busy, done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      tick();
    end
    checks++;
    if (saw_done) begin
      fails++;
      $display("FAIL abort quiet: activity=1 after reset, required 0");
    end
    run_op(2'b11, 16'h0100, 4'd8, 1'b0, res, lat, bcnt, seen);
    checks++;
    if (!seen || res !== 16'h0001 || lat != 8) begin
      fails++;
      $display("FAIL after abort: Out=%h latency=%0d, required 0001 latency=8", res, lat);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] res, x, exp;
    logic [1:0]  op;
    logic [3:0]  n;
    int lat, bcnt;
    bit seen;
    for (int i = 0; i < 160; i++) begin
      op = 2'(i % 4);
      n  = 4'((i / 4) % 16);
      x  = 16'($urandom);
      exp = model(op, x, int'(n));
      run_op(op, x, n, (i % 2) == 1, res, lat, bcnt, seen);
      checks++;
      if (!seen || res !== exp || lat != int'(n)) begin
        fails++;
        $display("FAIL random[%0d] op=%0d cnt=%0d in=%h: Out=%h latency=%0d, required %h latency=%0d",
                 i, op, n, x, res, lat, exp, n);
      end
      if ($urandom_range(1, 0) == 1) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
